cpu_axi_lite_master: RTL and testbench

- Sits directly downstream of the CPU-cycle address converter.
- Takes one decoded request (address, data, strobes, direction, address type) and, when the type is ADDR_TYPE_AXI, runs exactly one AXI4-Lite read or write transaction.
- Returns a byte of read data plus a completion pulse to the CPU wait-state logic.
- All other address types are left to the internal ROM/RAM/LED paths and are never issued on AXI.

---
 rtl/cpu_axi_lite_master.sv | 173 +++++++++++++++++
 tb/tb_cpu_axi_lite_master.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_lite_master.sv
// Single-outstanding AXI4-Lite master behind the CPU address converter.
// Turns one decoded AXI-type request into one read or write and returns a byte plus a done pulse.
module cpu_axi_lite_master #(
   parameter logic [2:0] AXI_PROT      = 3'b000,
   parameter logic [7:0] ERR_RDATA     = 8'hFF,
   parameter logic [2:0] ADDR_TYPE_AXI = 3'd3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_read,
   input  logic [2:0]  req_addr_type,
   input  logic [31:0] req_A32,
   input  logic [31:0] req_D32,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awprot,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic [31:0] m_axi_araddr,
   output logic [2:0]  m_axi_arprot,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready
);

   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE} state_t;

   state_t      state_q, state_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        arvalid_q, arvalid_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  strb_q, strb_d;
   logic [1:0]  lane_q, lane_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [7:0]  lane_byte;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         lane_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         strb_q    <= strb_d;
         lane_q    <= lane_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   // Byte lane picked by the address offset latched at acceptance.
   always_comb begin
      lane_byte = m_axi_rdata[7:0];
      case (lane_q)
         2'b00: lane_byte = m_axi_rdata[7:0];
         2'b01: lane_byte = m_axi_rdata[15:8];
         2'b10: lane_byte = m_axi_rdata[23:16];
         2'b11: lane_byte = m_axi_rdata[31:24];
         default: lane_byte = m_axi_rdata[7:0];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      addr_d    = addr_q;
      data_d    = data_q;
      strb_d    = strb_q;
      lane_d    = lane_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid && (req_addr_type == ADDR_TYPE_AXI)) begin
               addr_d = req_A32;
               data_d = req_D32;
               strb_d = req_wstrb;
               lane_d = req_A32[1:0];
               if (req_is_read) begin
                  arvalid_d = 1'b1;
                  state_d   = RD_AR;
               end else begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_AW_W;
               end
            end
         end
         WR_AW_W: begin
            // AW and W retire independently; move on once neither is outstanding.
            if (m_axi_awready) awvalid_d = 1'b0;
            if (m_axi_wready)  wvalid_d  = 1'b0;
            if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready))
               state_d = WR_B;
         end
         WR_B: begin
            if (m_axi_bvalid) begin
               err_d   = (m_axi_bresp != 2'b00);
               state_d = DONE;
            end
         end
         RD_AR: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = RD_R;
            end
         end
         RD_R: begin
            if (m_axi_rvalid) begin
               if (m_axi_rresp != 2'b00) begin
                  rdata_d = ERR_RDATA;
                  err_d   = 1'b1;
               end else begin
                  rdata_d = lane_byte;
                  err_d   = 1'b0;
               end
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign req_ready     = (state_q == IDLE);
   assign rsp_valid     = (state_q == DONE);
   assign rsp_rdata     = rdata_q;
   assign rsp_err       = err_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = AXI_PROT;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = data_q;
   assign m_axi_wstrb   = strb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = (state_q == WR_B);
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = AXI_PROT;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = (state_q == RD_R);

endmodule

// File: tb/tb_cpu_axi_lite_master.sv
// Randomized bench for cpu_axi_lite_master: behavioural slave with wait states and a byte-level reference model.
module tb_cpu_axi_lite_master;

   localparam logic [2:0] TYPE_AXI = 3'd3;
   localparam logic [2:0] TYPE_ROM = 3'd0;
   localparam logic [2:0] PROT     = 3'b000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_is_read = 1'b0;
   logic [2:0]  req_addr_type = 3'd0;
   logic [31:0] req_A32 = '0, req_D32 = '0;
   logic [3:0]  req_wstrb = '0;
   logic        rsp_valid, rsp_err;
   logic [7:0]  rsp_rdata;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
   logic [2:0]  m_axi_awprot, m_axi_arprot;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
   logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
   logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
   logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
   logic [31:0] m_axi_rdata = '0;

   int n_cmp = 0, n_bad = 0, cyc_cnt = 0;
   logic [7:0] exp_rdata = 8'h00;
   logic       exp_err = 1'b0;

   cpu_axi_lite_master #(.AXI_PROT(PROT), .ERR_RDATA(8'hFF), .ADDR_TYPE_AXI(TYPE_AXI)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_read(req_is_read),
      .req_addr_type(req_addr_type), .req_A32(req_A32), .req_D32(req_D32), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
      .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Reference: what the CPU should see once a transaction with these slave answers completes.
   task automatic model(input bit rd, input logic [31:0] a, input logic [1:0] resp, input logic [31:0] sdata);
      logic [31:0] sh;
      sh = sdata >> (8 * a[1:0]);
      exp_err = (resp != 2'b00);
      if (rd) exp_rdata = (resp != 2'b00) ? 8'hFF : sh[7:0];
   endtask

   // Issues one request and plays an AXI slave with the given per-channel wait counts; reports what it saw.
   task automatic run_txn(
      input bit rd, input logic [31:0] a, d, input logic [3:0] s,
      input int aw_w, w_w, ar_w, rb_w, input logic [1:0] resp, input logic [31:0] sdata,
      input bit hold, input int post,
      output logic [31:0] o_addr, o_wdata, output logic [3:0] o_strb, output logic [2:0] o_prot,
      output int n_aw, n_w, n_ar, n_rsp, rsp_cyc, aw_cyc, w_cyc, acc_cyc, viol,
      output logic [7:0] o_rdata, output logic o_err);
      int awc, wc, arc, bc, to, seen_post;
      bit aw_f, w_f, ar_f, x_f, aw_d, w_d, ar_d, x_d, got, p_aw, p_w, p_ar;
      logic [31:0] p_awaddr, p_wdata, p_araddr;
      logic [3:0]  p_strb;
      awc = 0; wc = 0; arc = 0; bc = 0; seen_post = 0;
      aw_f = 0; w_f = 0; ar_f = 0; x_f = 0; aw_d = 0; w_d = 0; ar_d = 0; x_d = 0; got = 0;
      p_aw = 0; p_w = 0; p_ar = 0; p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_strb = '0;
      o_addr = '0; o_wdata = '0; o_strb = '0; o_prot = 3'bxxx; o_rdata = '0; o_err = 0;
      n_aw = 0; n_w = 0; n_ar = 0; n_rsp = 0; rsp_cyc = -1; aw_cyc = -1; w_cyc = -1; viol = 0;
      req_valid = 1; req_is_read = rd; req_addr_type = TYPE_AXI;
      req_A32 = a; req_D32 = d; req_wstrb = s;
      to = 0;
      while (!req_ready && to < 50) begin @(posedge clk); #1; to++; end
      if (!req_ready) viol++;
      acc_cyc = cyc_cnt;
      @(posedge clk); #1;
      if (hold) req_is_read = ~rd;
      else req_valid = 0;
      for (int c = 0; c < 300; c++) begin
         if (aw_f) aw_d = 1;
         if (w_f)  w_d = 1;
         if (ar_f) ar_d = 1;
         if (x_f)  x_d = 1;
         if (p_aw && !aw_f && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) viol++;
         if (p_w && !w_f && (!m_axi_wvalid || m_axi_wdata !== p_wdata || m_axi_wstrb !== p_strb)) viol++;
         if (p_ar && !ar_f && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) viol++;
         if (rsp_valid) begin
            n_rsp++;
            if (!got) begin
               got = 1; rsp_cyc = c; o_rdata = rsp_rdata; o_err = rsp_err;
               req_valid = 0;
            end
         end
         if (got) begin
            if (seen_post >= post) break;
            seen_post++;
         end
         m_axi_awready = m_axi_awvalid && (awc >= aw_w); if (m_axi_awvalid) awc++;
         m_axi_wready  = m_axi_wvalid  && (wc >= w_w);   if (m_axi_wvalid)  wc++;
         m_axi_arready = m_axi_arvalid && (arc >= ar_w); if (m_axi_arvalid) arc++;
         aw_f = m_axi_awvalid && m_axi_awready;
         w_f  = m_axi_wvalid && m_axi_wready;
         ar_f = m_axi_arvalid && m_axi_arready;
         if (aw_f) begin n_aw++; aw_cyc = c; o_addr = m_axi_awaddr; o_prot = m_axi_awprot; end
         if (w_f)  begin n_w++; w_cyc = c; o_wdata = m_axi_wdata; o_strb = m_axi_wstrb; end
         if (ar_f) begin n_ar++; o_addr = m_axi_araddr; o_prot = m_axi_arprot; end
         m_axi_bvalid = 0; m_axi_rvalid = 0;
         m_axi_bresp = resp; m_axi_rresp = resp; m_axi_rdata = sdata;
         if (!rd && aw_d && w_d && !x_d) begin m_axi_bvalid = (bc >= rb_w); bc++; end
         if (rd && ar_d && !x_d) begin m_axi_rvalid = (bc >= rb_w); bc++; end
         x_f = (m_axi_bvalid && m_axi_bready) || (m_axi_rvalid && m_axi_rready);
         p_aw = m_axi_awvalid && !aw_f; p_awaddr = m_axi_awaddr;
         p_w  = m_axi_wvalid && !w_f;   p_wdata = m_axi_wdata; p_strb = m_axi_wstrb;
         p_ar = m_axi_arvalid && !ar_f; p_araddr = m_axi_araddr;
         @(posedge clk); #1;
      end
      if (!got) viol++;
      req_valid = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0; m_axi_bvalid = 0; m_axi_rvalid = 0;
   endtask

   logic [31:0] g_addr, g_wdata;
   logic [3:0]  g_strb;
   logic [2:0]  g_prot;
   int g_aw, g_w, g_ar, g_rsp, g_rc, g_awc, g_wc, g_acc, g_viol;
   logic [7:0]  g_rd;
   logic        g_err;

   task automatic test_reset();
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_hs: req_ready=%b rsp_valid=%b expected 1/0", req_ready, rsp_valid);
      end
      n_cmp++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
         n_bad++; $display("FAIL reset_axi_vr: got %b expected 00000",
            {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready});
      end
      n_cmp++;
      if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
         n_bad++; $display("FAIL reset_rsp: rdata=%h err=%b expected 00/0", rsp_rdata, rsp_err);
      end
      n_cmp++;
      if (m_axi_awaddr !== 32'h0 || m_axi_wdata !== 32'h0 || m_axi_wstrb !== 4'h0 || m_axi_araddr !== 32'h0) begin
         n_bad++; $display("FAIL reset_regs: aw=%h w=%h s=%h ar=%h expected all 0",
            m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr);
      end
   endtask

   task automatic test_read_lane();
      run_txn(1, 32'h4060_0002, 0, 0, 0, 0, 0, 3, 2'b00, 32'hAABB_CCDD, 0, 3,
              g_addr, g_wdata, g_strb, g_prot, g_aw, g_w, g_ar, g_rsp, g_rc, g_awc, g_wc, g_acc, g_viol, g_rd, g_err);
      model(1, 32'h4060_0002, 2'b00, 32'hAABB_CCDD);
      n_cmp++;
      if (g_addr !== 32'h4060_0002 || g_prot !== PROT) begin
         n_bad++; $display("FAIL read_lane_araddr: got %h/%b expected 40600002/%b", g_addr, g_prot, PROT);
      end
      n_cmp++;
      if (g_rd !== exp_rdata || g_err !== exp_err) begin
         n_bad++; $display("FAIL read_lane_data: got %h/%b expected %h/%b", g_rd, g_err, exp_rdata, exp_err);
      end
      n_cmp++;
      if (g_rsp != 1 || g_ar != 1 || g_aw != 0 || g_viol != 0) begin
         n_bad++; $display("FAIL read_lane_proto: rsp=%0d ar=%0d aw=%0d viol=%0d expected 1/1/0/0", g_rsp, g_ar, g_aw, g_viol);
      end
   endtask

   task automatic test_write_order();
      for (int k = 0; k < 2; k++) begin
         run_txn(0, 32'h4060_0004, 32'h0000_0041, 4'b0001, 0, (k == 0) ? 2 : 0, 0, 0, 2'b00, 32'h0, 0, 3,
                 g_addr, g_wdata, g_strb, g_prot, g_aw, g_w, g_ar, g_rsp, g_rc, g_awc, g_wc, g_acc, g_viol, g_rd, g_err);
         model(0, 32'h4060_0004, 2'b00, 32'h0);
         n_cmp++;
         if (g_addr !== 32'h4060_0004 || g_wdata !== 32'h41 || g_strb !== 4'b0001) begin
            n_bad++; $display("FAIL write_fields%0d: got %h/%h/%b expected 40600004/00000041/0001", k, g_addr, g_wdata, g_strb);
         end
         n_cmp++;
         if (g_aw != 1 || g_w != 1 || g_rsp != 1 || g_viol != 0 || g_ar != 0) begin
            n_bad++; $display("FAIL write_proto%0d: aw=%0d w=%0d rsp=%0d viol=%0d ar=%0d expected 1/1/1/0/0",
               k, g_aw, g_w, g_rsp, g_viol, g_ar);
         end
         n_cmp++;
         if ((k == 0) ? !(g_awc < g_wc) : (g_awc != g_wc)) begin
            n_bad++; $display("FAIL write_order%0d: aw_cyc=%0d w_cyc=%0d", k, g_awc, g_wc);
         end
         n_cmp++;
         if (g_rd !== exp_rdata || g_err !== exp_err) begin
            n_bad++; $display("FAIL write_rsp%0d: got %h/%b expected %h/%b", k, g_rd, g_err, exp_rdata, exp_err);
         end
      end
      n_cmp++;
      if (g_rc != 2) begin
         n_bad++; $display("FAIL write_latency: rsp at cycle %0d expected 2", g_rc);
      end
   endtask

   task automatic test_read_err();
      run_txn(1, 32'h4060_0001, 0, 0, 0, 0, 0, 0, 2'b10, 32'h1234_5678, 0, 2,
              g_addr, g_wdata, g_strb, g_prot, g_aw, g_w, g_ar, g_rsp, g_rc, g_awc, g_wc, g_acc, g_viol, g_rd, g_err);
      model(1, 32'h4060_0001, 2'b10, 32'h1234_5678);
      n_cmp++;
      if (g_rd !== exp_rdata || g_err !== exp_err || g_rsp != 1) begin
         n_bad++; $display("FAIL read_err: got %h/%b/%0d expected %h/%b/1", g_rd, g_err, g_rsp, exp_rdata, exp_err);
      end
      n_cmp++;
      if (g_rc != 2) begin
         n_bad++; $display("FAIL read_latency: rsp at cycle %0d expected 2", g_rc);
      end
      run_txn(1, 32'h4060_0003, 0, 0, 1, 0, 2, 1, 2'b00, 32'h9A00_0000, 0, 2,
              g_addr, g_wdata, g_strb, g_prot, g_aw, g_w, g_ar, g_rsp, g_rc, g_awc, g_wc, g_acc, g_viol, g_rd, g_err);
      model(1, 32'h4060_0003, 2'b00, 32'h9A00_0000);
      n_cmp++;
      if (g_rd !== exp_rdata || g_err !== exp_err || g_viol != 0) begin
         n_bad++; $display("FAIL read_err_clear: got %h/%b viol=%0d expected %h/%b/0", g_rd, g_err, g_viol, exp_rdata, exp_err);
      end
   endtask

   task automatic test_ignore();
      int bad;
      bad = 0;
      req_valid = 1; req_is_read = 0; req_addr_type = TYPE_ROM; req_A32 = 32'h4060_0000;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid || !req_ready || rsp_valid) bad++;
      end
      req_valid = 0;
      n_cmp++;
      if (bad != 0) begin
         n_bad++; $display("FAIL ignore_rom: %0d bad cycles expected 0", bad);
      end
      // Read held open on R while a second AXI write request sits on req_valid.
      run_txn(1, 32'h4060_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 4, 2'b00, 32'h0000_0077, 1, 4,
              g_addr, g_wdata, g_strb, g_prot, g_aw, g_w, g_ar, g_rsp, g_rc, g_awc, g_wc, g_acc, g_viol, g_rd, g_err);
      model(1, 32'h4060_0000, 2'b00, 32'h0000_0077);
      n_cmp++;
      if (g_aw != 0 || g_w != 0 || g_ar != 1 || g_rsp != 1 || g_rd !== exp_rdata) begin
         n_bad++; $display("FAIL ignore_busy: aw=%0d w=%0d ar=%0d rsp=%0d rd=%h expected 0/0/1/1/%h",
            g_aw, g_w, g_ar, g_rsp, g_rd, exp_rdata);
      end
   endtask

   task automatic test_back_to_back();
      int a0;
      run_txn(0, 32'h4000_0010, 32'h1111_2222, 4'b1100, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0,
              g_addr, g_wdata, g_strb, g_prot, g_aw, g_w, g_ar, g_rsp, g_rc, g_awc, g_wc, g_acc, g_viol, g_rd, g_err);
      model(0, 32'h4000_0010, 2'b00, 32'h0);
      a0 = g_acc;
      run_txn(1, 32'h4000_0012, 0, 0, 0, 0, 0, 0, 2'b00, 32'h00C3_0000, 0, 2,
              g_addr, g_wdata, g_strb, g_prot, g_aw, g_w, g_ar, g_rsp, g_rc, g_awc, g_wc, g_acc, g_viol, g_rd, g_err);
      model(1, 32'h4000_0012, 2'b00, 32'h00C3_0000);
      n_cmp++;
      if (g_acc - a0 != 4) begin
         n_bad++; $display("FAIL b2b_spacing: got %0d cycles expected 4", g_acc - a0);
      end
      n_cmp++;
      if (g_rd !== exp_rdata || g_rsp != 1) begin
         n_bad++; $display("FAIL b2b_data: got %h/%0d expected %h/1", g_rd, g_rsp, exp_rdata);
      end
   endtask

   task automatic test_random();
      bit rd;
      logic [31:0] a, d, sd;
      logic [3:0] s;
      logic [1:0] resp;
      for (int i = 0; i < 40; i++) begin
         rd = $urandom_range(0, 1);
         a = $urandom; d = $urandom; sd = $urandom; s = 4'($urandom);
         resp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         run_txn(rd, a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), resp, sd, 0, 1,
                 g_addr, g_wdata, g_strb, g_prot, g_aw, g_w, g_ar, g_rsp, g_rc, g_awc, g_wc, g_acc, g_viol, g_rd, g_err);
         model(rd, a, resp, sd);
         n_cmp++;
         if (g_addr !== a || g_rd !== exp_rdata || g_err !== exp_err || g_rsp != 1 || g_viol != 0) begin
            n_bad++; $display("FAIL rand%0d: rd=%b addr %h/%h rdata %h/%h err %b/%b rsp=%0d viol=%0d",
               i, rd, g_addr, a, g_rd, exp_rdata, g_err, exp_err, g_rsp, g_viol);
         end
         n_cmp++;
         if (rd ? (g_aw != 0 || g_w != 0 || g_ar != 1)
                : (g_aw != 1 || g_w != 1 || g_ar != 0 || g_wdata !== d || g_strb !== s)) begin
            n_bad++; $display("FAIL rand%0d_chan: aw=%0d w=%0d ar=%0d wdata %h/%h strb %b/%b",
               i, g_aw, g_w, g_ar, g_wdata, d, g_strb, s);
         end
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      bad = 0;
      req_valid = 1; req_is_read = 0; req_addr_type = TYPE_AXI;
      req_A32 = 32'h4060_0008; req_D32 = 32'h55; req_wstrb = 4'b0001;
      while (!req_ready) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      req_valid = 0;
      @(posedge clk); #1;
      n_cmp++;
      if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin
         n_bad++; $display("FAIL rstmid_pre: aw=%b w=%b expected 1/1", m_axi_awvalid, m_axi_wvalid);
      end
      rst = 1; #1;
      n_cmp++;
      if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_async: aw=%b w=%b expected 0/0", m_axi_awvalid, m_axi_wvalid);
      end
      exp_rdata = 8'h00; exp_err = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (!req_ready || rsp_valid || m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) bad++;
      end
      n_cmp++;
      if (bad != 0 || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
         n_bad++; $display("FAIL rstmid_after: bad=%0d rdata=%h err=%b expected 0/%h/%b", bad, rsp_rdata, rsp_err, exp_rdata, exp_err);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(posedge clk); #1;
      test_reset();
      test_read_lane();
      test_write_order();
      test_read_err();
      test_ignore();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
